// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared constants, helpers and stage payload type for the fpcvt converter
package fpcvt_pkg;

    // Ceiling log2 for sizing position/exponent fields from parameters.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Largest encodable exponent for a given exponent field width.
    function automatic int exp_limit(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // The S2 payload is declared at fixed maximum widths so one type serves
    // every parameterisation; the pipeline uses only the low bits it needs.
    // Supported: MAN_W <= S2_SIG_BITS and working exponent width <= S2_EXP_BITS.
    localparam int S2_EXP_BITS = 8;
    localparam int S2_SIG_BITS = 32;

    typedef struct packed {
        logic                   sign;
        logic [S2_EXP_BITS-1:0] exp;
        logic [S2_SIG_BITS-1:0] sig;
        logic                   rbit;
        logic                   sticky;
        logic                   round_en;
    } s2_payload_t;

endpackage

// File: rtl/fpcvt_lod.sv
// rtl/fpcvt_lod.sv - combinational leading-one detector
//   i_mag  : unsigned magnitude
//   o_pos  : index of the most significant set bit (0 when i_mag is zero)
//   o_zero : i_mag is all zeros
module fpcvt_lod
    import fpcvt_pkg::*;
#(
    parameter int W  = 12,
    parameter int PW = clog2(W)
) (
    input  logic [W-1:0]  i_mag,
    output logic [PW-1:0] o_pos,
    output logic          o_zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        o_pos  = '0;
        o_zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (i_mag[i]) begin
                o_pos  = PW'(i);
                o_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// rtl/fpcvt_pipe.sv - 3-stage two's-complement to sign/exponent/significand converter
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     : sample handshake, IN_W-bit two's complement
//   in_round                      : 1 = round half up on magnitude, 0 = truncate
//   out_valid/out_ready/out_data  : result handshake, {sign, exp, sig}
//   out_sat, out_inexact          : clamped to max magnitude / discarded bits nonzero
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter  int IN_W  = 12,
    parameter  int EXP_W = 3,
    parameter  int MAN_W = 4,
    localparam int OUT_W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_inexact
);

    localparam int PW      = (clog2(IN_W) < 1) ? 1 : clog2(IN_W);
    localparam int EW0     = clog2(IN_W + 1);
    // Working exponent keeps one spare bit so the renormalisation carry and
    // the saturation compare never wrap.
    localparam int EW      = ((EW0 > EXP_W) ? EW0 : EXP_W) + 1;
    localparam int EXP_LIM = exp_limit(EXP_W);

    logic              r_v1, r_v2, r_v3;
    logic              w_ld1, w_ld2, w_ld3;

    logic              r_s1_sign;
    logic [IN_W-1:0]   r_s1_mag;
    logic              r_s1_rnd;

    logic [PW-1:0]     w_p;
    logic              w_zero;
    int                w_e_int;
    logic [EW-1:0]     w_e;
    logic [IN_W-1:0]   w_shift;
    logic [IN_W-1:0]   w_mask;
    logic [IN_W-1:0]   w_rmask;
    s2_payload_t       w_s2;
    s2_payload_t       r_s2;

    logic [MAN_W:0]    w_sig_inc;
    logic [EW-1:0]     w_e3;
    logic [MAN_W-1:0]  w_sig3;
    logic              w_sat3;
    logic              w_inexact3;
    logic [OUT_W-1:0]  w_out3;
    logic              w_unused;

    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_sat;
    logic              r_out_inexact;

    // A stage may load when it is empty or its occupant leaves this cycle;
    // the chain runs combinationally back from out_ready.
    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;

    // S1: sign and magnitude. The most-negative input maps to 2^(IN_W-1),
    // which still fits in IN_W unsigned bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_mag  <= '0;
            r_s1_rnd  <= 1'b0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_data[IN_W-1];
                r_s1_mag  <= in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
                r_s1_rnd  <= in_round;
            end
        end
    end

    fpcvt_lod #(.W(IN_W), .PW(PW)) u_lod (
        .i_mag  (r_s1_mag),
        .o_pos  (w_p),
        .o_zero (w_zero)
    );

    // S2 datapath: w_mask covers every discarded bit, w_rmask only the
    // highest of them (the round bit).
    always_comb begin
        w_e_int = 0;
        if (int'(w_p) >= MAN_W - 1) begin
            w_e_int = int'(w_p) - (MAN_W - 1);
        end
        w_e     = EW'(w_e_int);
        w_shift = r_s1_mag >> w_e;
        w_mask  = (IN_W'(1) << w_e) - IN_W'(1);
        w_rmask = w_mask & ~(w_mask >> 1);
        w_s2    = '0;
        if (!w_zero) begin
            w_s2.sign           = r_s1_sign;
            w_s2.exp[EW-1:0]    = w_e;
            w_s2.sig[MAN_W-1:0] = w_shift[MAN_W-1:0];
            w_s2.rbit           = (r_s1_mag & w_rmask) != '0;
            w_s2.sticky         = (r_s1_mag & w_mask) != '0;
            w_s2.round_en       = r_s1_rnd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2 <= w_s2;
            end
        end
    end

    // S3: round, renormalise on significand carry-out, saturate, pack.
    // Saturation always loses magnitude, so it always reports inexact.
    always_comb begin
        w_sig_inc  = {1'b0, r_s2.sig[MAN_W-1:0]} + {{MAN_W{1'b0}}, r_s2.rbit & r_s2.round_en};
        w_e3       = r_s2.exp[EW-1:0];
        w_sig3     = w_sig_inc[MAN_W-1:0];
        if (w_sig_inc[MAN_W]) begin
            w_sig3 = MAN_W'(1) << (MAN_W - 1);
            w_e3   = w_e3 + EW'(1);
        end
        w_sat3     = w_e3 > EW'(EXP_LIM);
        w_inexact3 = r_s2.sticky || w_sat3;
        if (w_sat3) begin
            w_out3 = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        end else begin
            w_out3 = {r_s2.sign, w_e3[EXP_W-1:0], w_sig3};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3          <= 1'b0;
            r_out_data    <= '0;
            r_out_sat     <= 1'b0;
            r_out_inexact <= 1'b0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_out_data    <= w_out3;
                r_out_sat     <= w_sat3;
                r_out_inexact <= w_inexact3;
            end
        end
    end

    assign out_valid   = r_v3;
    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign out_inexact = r_out_inexact;

    // Upper payload bits and high shifted bits are intentionally dropped.
    assign w_unused = ^{r_s2, w_shift};

endmodule

// File: tb/tb_fpcvt_pipe.sv
// tb/tb_fpcvt_pipe.sv - scoreboard bench for fpcvt_pipe at three parameter sets
module tb_fpcvt_pipe;

    typedef struct packed {
        logic [17:0] res;
        logic        lat;
        logic [31:0] issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic        a_in_valid = 1'b0, a_in_round = 1'b0, a_out_ready = 1'b1;
    logic [11:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_sat, a_out_inexact;
    logic [7:0]  a_out_data;

    logic        b_in_valid = 1'b0, b_in_round = 1'b0, b_out_ready = 1'b1;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_sat, b_out_inexact;
    logic [10:0] b_out_data;

    logic        c_in_valid = 1'b0, c_in_round = 1'b0, c_out_ready = 1'b1;
    logic [7:0]  c_in_data = '0;
    logic        c_in_ready, c_out_valid, c_out_sat, c_out_inexact;
    logic [5:0]  c_out_data;

    logic bp_on = 1'b0;
    int   bp_k = 0;
    int   occ = 0;

    fpcvt_pipe #(.IN_W(12), .EXP_W(3), .MAN_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_round(a_in_round), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_sat(a_out_sat),
        .out_inexact(a_out_inexact));

    fpcvt_pipe #(.IN_W(16), .EXP_W(4), .MAN_W(6)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_round(b_in_round), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_sat(b_out_sat),
        .out_inexact(b_out_inexact));

    fpcvt_pipe #(.IN_W(8), .EXP_W(2), .MAN_W(3)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_round(c_in_round), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_sat(c_out_sat),
        .out_inexact(c_out_inexact));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Arithmetic reference: returns {sat, inexact, data[15:0]}.
    function automatic logic [17:0] model(input longint raw, input int in_w, input int exp_w,
                                          input int man_w, input bit rnd);
        longint v, mag, sig, emax, word;
        int     p, e;
        bit     sign, inex, sat;
        v    = raw & ((longint'(1) << in_w) - 1);
        sign = ((v >> (in_w - 1)) & 1) != 0;
        if (sign) v = v - (longint'(1) << in_w);
        mag = sign ? -v : v;
        if (mag == 0) return 18'd0;
        p = 0;
        for (int i = 0; i < in_w; i++) if (((mag >> i) & 1) != 0) p = i;
        e    = (p - man_w + 1 > 0) ? p - man_w + 1 : 0;
        sig  = (mag >> e) & ((longint'(1) << man_w) - 1);
        inex = (mag & ((longint'(1) << e) - 1)) != 0;
        if (rnd && e > 0 && (((mag >> (e - 1)) & 1) != 0)) begin
            sig++;
            if (sig == (longint'(1) << man_w)) begin
                sig = longint'(1) << (man_w - 1);
                e++;
            end
        end
        emax = (longint'(1) << exp_w) - 1;
        sat  = e > emax;
        if (sat) begin
            e    = int'(emax);
            sig  = (longint'(1) << man_w) - 1;
            inex = 1'b1;
        end
        word = (longint'(sign) << (exp_w + man_w)) | (longint'(e) << man_w) | sig;
        return {sat, inex, word[15:0]};
    endfunction

    task automatic send_a(input logic [11:0] d, input bit rnd, input logic [17:0] res, input bit lat);
        exp_t e;
        int   n;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_round = rnd;
        #1; n = 0;
        while (!a_in_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk("a_accept", a_in_ready, 1);
        if (a_in_ready) begin e.res = res; e.lat = lat; e.issue = cyc; q_a.push_back(e); end
        @(posedge clk); #1; a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input bit rnd);
        exp_t e;
        int   n;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = d; b_in_round = rnd;
        #1; n = 0;
        while (!b_in_ready && n < 200) begin @(negedge clk); #1; n++; end
        if (!b_in_ready) chk("b_accept", b_in_ready, 1);
        else begin e.res = model(longint'(d), 16, 4, 6, rnd); e.lat = 0; e.issue = cyc; q_b.push_back(e); end
        @(posedge clk); #1; b_in_valid = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input bit rnd);
        exp_t e;
        int   n;
        @(negedge clk);
        c_in_valid = 1'b1; c_in_data = d; c_in_round = rnd;
        #1; n = 0;
        while (!c_in_ready && n < 200) begin @(negedge clk); #1; n++; end
        if (!c_in_ready) chk("c_accept", c_in_ready, 1);
        else begin e.res = model(longint'(d), 8, 2, 3, rnd); e.lat = 0; e.issue = cyc; q_c.push_back(e); end
        @(posedge clk); #1; c_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_left", q_a.size() + q_b.size() + q_c.size(), 0);
    endtask

    // Monitors: pop on transfer, compare head against a stalled output.
    always begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && a_out_valid) begin
            if (q_a.size() == 0) chk("a_spurious_valid", a_out_valid, 0);
            else if (!a_out_ready) chk("a_hold", {a_out_sat, a_out_inexact, 8'h00, a_out_data}, q_a[0].res);
            else begin
                e = q_a.pop_front();
                chk("a_out", {a_out_sat, a_out_inexact, 8'h00, a_out_data}, e.res);
                if (e.lat) chk("a_latency", cyc - e.issue, 3);
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && b_out_valid) begin
            if (q_b.size() == 0) chk("b_spurious_valid", b_out_valid, 0);
            else if (!b_out_ready) chk("b_hold", {b_out_sat, b_out_inexact, 5'h00, b_out_data}, q_b[0].res);
            else begin
                e = q_b.pop_front();
                chk("b_out", {b_out_sat, b_out_inexact, 5'h00, b_out_data}, e.res);
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && c_out_valid && c_out_ready) begin
            if (q_c.size() == 0) chk("c_spurious_valid", c_out_valid, 0);
            else begin
                e = q_c.pop_front();
                chk("c_out", {c_out_sat, c_out_inexact, 10'h000, c_out_data}, e.res);
            end
        end
    end

    // Occupancy of pipe A: in_ready must drop exactly when three samples
    // are held and the consumer stalls.
    always begin
        @(negedge clk); #3;
        if (rst) occ = 0;
        else begin
            if (bp_on) begin
                chk("a_in_ready_bp", a_in_ready, !(occ == 3 && !a_out_ready));
                if (occ > 3) chk("a_occupancy", occ, 3);
            end
            occ = occ + int'(a_in_valid && a_in_ready) - int'(a_out_valid && a_out_ready);
        end
    end

    always begin
        @(negedge clk);
        if (bp_on) begin a_out_ready = (bp_k % 3 == 0); bp_k++; end
    end

    always begin
        @(negedge clk);
        b_out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [11:0] vals[10];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_flags", {a_out_sat, a_out_inexact}, 0);

        // Directed vectors: data, round, expected {sat, inexact, data}.
        send_a(12'd0,    1, {1'b0, 1'b0, 16'h0000}, 1);
        send_a(12'd5,    1, {1'b0, 1'b0, 16'h0005}, 1);
        send_a(12'd422,  1, {1'b0, 1'b1, 16'h005D}, 1);
        send_a(12'd125,  1, {1'b0, 1'b1, 16'h0048}, 1);
        send_a(12'd125,  0, {1'b0, 1'b1, 16'h003F}, 1);
        send_a(12'hE5A,  1, {1'b0, 1'b1, 16'h00DD}, 1);
        send_a(12'd2047, 1, {1'b1, 1'b1, 16'h007F}, 1);
        send_a(12'd2047, 0, {1'b0, 1'b1, 16'h007F}, 1);
        send_a(12'h800,  1, {1'b1, 1'b1, 16'h00FF}, 1);
        send_a(12'd1920, 1, {1'b0, 1'b0, 16'h007F}, 1);
        send_a(12'hFFF,  1, {1'b0, 1'b0, 16'h0081}, 1);
        send_a(12'd16,   1, {1'b0, 1'b0, 16'h0018}, 1);
        send_a(12'd17,   1, {1'b0, 1'b1, 16'h0019}, 1);
        send_a(12'd31,   1, {1'b0, 1'b1, 16'h0028}, 1);
        wait_drain();

        // Backpressure: 10 back-to-back samples, out_ready 1,0,0 repeating.
        vals = '{12'd7, 12'd100, 12'hF00, 12'd2000, 12'd63, 12'd64, 12'h801, 12'd333, 12'd9, 12'd1023};
        bp_on = 1'b1;
        for (int i = 0; i < 10; i++) send_a(vals[i], i[0], model(longint'(vals[i]), 12, 3, 4, i[0]), 0);
        wait_drain();
        bp_on = 1'b0;
        @(negedge clk);
        a_out_ready = 1'b0;

        // Reset with three samples in flight.
        send_a(12'd50, 1, model(50, 12, 3, 4, 1), 0);
        send_a(12'd60, 1, model(60, 12, 3, 4, 1), 0);
        send_a(12'd70, 1, model(70, 12, 3, 4, 1), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_out_data", a_out_data, 0);
        chk("arst_flags", {a_out_sat, a_out_inexact}, 0);
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        #1;
        chk("arst_in_ready", a_in_ready, 1);
        repeat (6) @(negedge clk);
        send_a(12'd5, 1, {1'b0, 1'b0, 16'h0005}, 1);
        wait_drain();

        // Wide parameter set: random inputs and round mode under random backpressure.
        for (int i = 0; i < 10000; i++) send_b(16'($urandom()), 1'($urandom_range(0, 1)));
        wait_drain();

        // Narrow parameter set: exhaustive inputs in both round modes.
        for (int i = 0; i < 256; i++) begin
            send_c(8'(i), 1'b0);
            send_c(8'(i), 1'b1);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
